// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Lets the cpu instruction-fetch port and the cpu load/store port share one
// single-ported memory. Only one transaction is in flight at a time. A
// transaction is issued to memory for one cycle. For a read, the block then
// waits LATENCY cycles and returns mem_rdata to the requester that owns the
// transaction, together with a one-cycle valid pulse.
//
// Arbitration:
//   Default build  : the data port always wins over the instruction port.
//   MEM_ARB_RR_EN  : on a tie, the port that did not win last time wins.
//
// Parameters:
//   LATENCY  memory read latency in cycles, from mem_en to valid mem_rdata (1..15)
//   AW       address width
//   DW       data width
//
// Ports:
//   clock, reset                    rising-edge clock; asynchronous active-high reset
//   inst_req/addr                   instruction read request, held until inst_gnt
//   inst_gnt/rvalid/rdata           grant pulse, read-valid pulse, read data
//   data_req/rw/addr/wdata          data request (rw=1 means write), held until data_gnt
//   data_gnt/rvalid/rdata           grant pulse, read-valid pulse (reads only), read data
//   mem_en/rw/addr/wdata            memory strobe and command, valid in the issue cycle
//   mem_rdata                       memory read data, valid LATENCY cycles after mem_en

module mem_port_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_gnt,
  output logic          inst_rvalid,
  output logic [DW-1:0] inst_rdata,

  input  logic          data_req,
  input  logic          data_rw,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,

  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // The counter is loaded with LATENCY-1 on entry to WAIT. WAIT is left on
  // the cycle in which the counter reads 1, so that RESP falls exactly
  // LATENCY cycles after ISSUE.
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;        // 1 = data port owns the transaction
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] inst_hold_q, inst_hold_d;
  logic [DW-1:0] data_hold_q, data_hold_d;
  logic          pick_data;

`ifdef MEM_ARB_RR_EN
  logic          last_q, last_d;          // 1 = data port won the previous grant
`endif

  // Winner selection. This is only used in IDLE, when at least one request
  // is high.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (data_req && inst_req) begin
      pick_data = ~last_q;
    end else begin
      pick_data = data_req;
    end
`else
    pick_data = data_req;
`endif
  end

  // Next-state logic for the transaction sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          owner_d = pick_data;
          rw_d    = pick_data & data_rw;
          addr_d  = pick_data ? data_addr : inst_addr;
          wdata_d = pick_data ? data_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_data;
`endif
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (rw_q) begin
          state_d = IDLE;
        end else if (LATENCY == 1) begin
          state_d = RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_q) begin
          data_hold_d = mem_rdata;
        end else begin
          inst_hold_d = mem_rdata;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers. Reset drops any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Output decode. The memory command is forced to zero outside ISSUE, so the
  // bus stays quiet while idle or waiting. Read data is passed straight
  // through in RESP. At all other times each port shows its last response.
  always_comb begin
    mem_en      = (state_q == ISSUE);
    mem_rw      = mem_en & rw_q;
    mem_addr    = mem_en ? addr_q : '0;
    mem_wdata   = mem_en ? wdata_q : '0;
    inst_gnt    = mem_en & ~owner_q;
    data_gnt    = mem_en & owner_q;
    inst_rvalid = (state_q == RESP) & ~owner_q;
    data_rvalid = (state_q == RESP) & owner_q;
    inst_rdata  = inst_rvalid ? mem_rdata : inst_hold_q;
    data_rdata  = data_rvalid ? mem_rdata : data_hold_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Two instances are built:
// index 0 with LATENCY=1 and index 1 with LATENCY=3. Each instance is
// attached to a small behavioural memory with the matching read latency.
//
// A transaction-level model predicts every output on every cycle. Each
// accepted request is stored as a set of timestamps: the grant cycle, the
// response cycle and the cycle in which the arbiter is free again. Directed
// sequences also check literal values at hand-computed cycles. Build with
// +define+MEM_ARB_RR_EN to cover round-robin arbitration.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic clock;
  logic reset;

  logic [1:0]       inst_req, inst_gnt, inst_rvalid;
  logic [1:0][31:0] inst_addr, inst_rdata;
  logic [1:0]       data_req, data_rw, data_gnt, data_rvalid;
  logic [1:0][31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]       mem_en, mem_rw;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

  int cmp_count  = 0;
  int fail_count = 0;
  int cyc        = 0;

  mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut0 (
    .clock(clock), .reset(reset),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]), .inst_gnt(inst_gnt[0]),
    .inst_rvalid(inst_rvalid[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_rw(data_rw[0]), .data_addr(data_addr[0]),
    .data_wdata(data_wdata[0]), .data_gnt(data_gnt[0]),
    .data_rvalid(data_rvalid[0]), .data_rdata(data_rdata[0]),
    .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.LATENCY(3), .AW(32), .DW(32)) u_dut1 (
    .clock(clock), .reset(reset),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]), .inst_gnt(inst_gnt[1]),
    .inst_rvalid(inst_rvalid[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_rw(data_rw[1]), .data_addr(data_addr[1]),
    .data_wdata(data_wdata[1]), .data_gnt(data_gnt[1]),
    .data_rvalid(data_rvalid[1]), .data_rdata(data_rdata[1]),
    .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Clock generation and the cycle counter.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Memory contents that have never been written. Address 0x100 is preloaded
  // with 0xDEADBEEF. Every other word reads as 0xC0DE followed by the low 16
  // address bits.
  function automatic logic [31:0] mem_init(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Behavioural memories. Read data travels down a delay line and appears
  // exactly LATENCY cycles after the mem_en cycle. In every other cycle the
  // memory drives a changing junk value.
  logic [31:0] mem_store   [2][1024];
  logic        mem_written [2][1024];
  logic [3:0]  pipe_v      [2];
  logic [31:0] pipe_d      [2][4];

  function automatic logic [31:0] mem_read(input int g, input logic [31:0] addr);
    if (mem_written[g][addr[11:2]] === 1'b1) return mem_store[g][addr[11:2]];
    return mem_init(addr);
  endfunction

  always @(posedge clock) begin
    for (int g = 0; g < 2; g++) begin
      pipe_v[g] <= {pipe_v[g][2:0], mem_en[g] & ~mem_rw[g]};
      for (int k = 3; k > 0; k--) pipe_d[g][k] <= pipe_d[g][k-1];
      pipe_d[g][0] <= mem_read(g, mem_addr[g]);
      if (mem_en[g] === 1'b1 && mem_rw[g] === 1'b1) begin
        mem_store[g][mem_addr[g][11:2]]   <= mem_wdata[g];
        mem_written[g][mem_addr[g][11:2]] <= 1'b1;
      end
    end
  end

  assign mem_rdata[0] = (pipe_v[0][0] === 1'b1) ? pipe_d[0][0] : (32'hBAD00000 ^ 32'(cyc));
  assign mem_rdata[1] = (pipe_v[1][2] === 1'b1) ? pipe_d[1][2] : (32'hBAD00000 ^ 32'(cyc));

  // Shared comparison helper. Every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    cmp_count = cmp_count + 1;
    if (act !== want) begin
      fail_count = fail_count + 1;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Transaction-level model state, one entry per instance.
  int          gnt_at  [2];
  int          free_at [2];
  logic        owner_data [2];
  logic        tx_rw   [2];
  logic [31:0] tx_addr [2];
  logic [31:0] tx_wdata[2];
  logic [31:0] hold_i  [2];
  logic [31:0] hold_d  [2];
  logic [31:0] sh_store   [2][1024];
  logic        sh_written [2][1024];
`ifdef MEM_ARB_RR_EN
  logic        last_data [2];
`endif

  function automatic logic [31:0] sh_read(input int i, input logic [31:0] addr);
    if (sh_written[i][addr[11:2]] === 1'b1) return sh_store[i][addr[11:2]];
    return mem_init(addr);
  endfunction

  task automatic compare_all(input int i,
                             input logic eig, input logic eiv, input logic [31:0] eir,
                             input logic edg, input logic edv, input logic [31:0] edr,
                             input logic eme, input logic chk_mem, input logic emrw,
                             input logic [31:0] ema, input logic chk_w, input logic [31:0] emw);
    checkOutput($sformatf("model inst_gnt[%0d]", i),    32'(inst_gnt[i]),    32'(eig));
    checkOutput($sformatf("model inst_rvalid[%0d]", i), 32'(inst_rvalid[i]), 32'(eiv));
    checkOutput($sformatf("model inst_rdata[%0d]", i),  inst_rdata[i],       eir);
    checkOutput($sformatf("model data_gnt[%0d]", i),    32'(data_gnt[i]),    32'(edg));
    checkOutput($sformatf("model data_rvalid[%0d]", i), 32'(data_rvalid[i]), 32'(edv));
    checkOutput($sformatf("model data_rdata[%0d]", i),  data_rdata[i],       edr);
    checkOutput($sformatf("model mem_en[%0d]", i),      32'(mem_en[i]),      32'(eme));
    if (chk_mem) begin
      checkOutput($sformatf("model mem_rw[%0d]", i),    32'(mem_rw[i]),      32'(emrw));
      checkOutput($sformatf("model mem_addr[%0d]", i),  mem_addr[i],         ema);
    end
    if (chk_w) begin
      checkOutput($sformatf("model mem_wdata[%0d]", i), mem_wdata[i],        emw);
    end
  endtask

  // Compare process. On every falling edge it predicts the outputs of both
  // instances from the model and checks them. It then lets the model accept
  // a new request if the arbiter is free in this cycle.
  initial begin
    for (int i = 0; i < 2; i++) begin
      gnt_at[i] = -100; free_at[i] = 0; owner_data[i] = 1'b0; tx_rw[i] = 1'b0;
      tx_addr[i] = '0; tx_wdata[i] = '0; hold_i[i] = '0; hold_d[i] = '0;
`ifdef MEM_ARB_RR_EN
      last_data[i] = 1'b0;
`endif
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          compare_all(i, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
          gnt_at[i] = -100; free_at[i] = 0; tx_rw[i] = 1'b0;
          hold_i[i] = '0; hold_d[i] = '0;
`ifdef MEM_ARB_RR_EN
          last_data[i] = 1'b0;
`endif
        end else begin
          logic is_gnt, is_rv, pick;
          is_gnt = (cyc == gnt_at[i]);
          is_rv  = !tx_rw[i] && (cyc == gnt_at[i] + lat(i));
          if (is_rv) begin
            if (owner_data[i]) hold_d[i] = sh_read(i, tx_addr[i]);
            else               hold_i[i] = sh_read(i, tx_addr[i]);
          end
          if (is_gnt && tx_rw[i]) begin
            sh_store[i][tx_addr[i][11:2]]   = tx_wdata[i];
            sh_written[i][tx_addr[i][11:2]] = 1'b1;
          end
          compare_all(i, is_gnt && !owner_data[i], is_rv && !owner_data[i], hold_i[i],
                      is_gnt && owner_data[i], is_rv && owner_data[i], hold_d[i],
                      is_gnt, is_gnt, tx_rw[i], tx_addr[i], is_gnt && tx_rw[i], tx_wdata[i]);
          if (cyc >= free_at[i] && (inst_req[i] || data_req[i])) begin
            pick = data_req[i];
`ifdef MEM_ARB_RR_EN
            if (inst_req[i] && data_req[i]) pick = !last_data[i];
            last_data[i] = pick;
`endif
            owner_data[i] = pick;
            tx_rw[i]      = pick ? data_rw[i] : 1'b0;
            tx_addr[i]    = pick ? data_addr[i] : inst_addr[i];
            tx_wdata[i]   = data_wdata[i];
            gnt_at[i]     = cyc + 1;
            free_at[i]    = cyc + 1 + (tx_rw[i] ? 1 : lat(i) + 1);
          end
        end
      end
    end
  end

  // Directed stimulus helpers. Inputs change 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic drw, input logic [31:0] da,
                               input logic [31:0] dw);
    inst_req[i]   = ir;
    inst_addr[i]  = ia;
    data_req[i]   = dr;
    data_rw[i]    = drw;
    data_addr[i]  = da;
    data_wdata[i] = dw;
  endtask

  logic [3:0] rr_expect_data;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Instruction read on the LATENCY=1 instance.
    next_cycle(); applyStimulus(0, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t1 gnt before issue", 32'(inst_gnt[0]), 32'd0);
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t1 inst_gnt", 32'(inst_gnt[0]), 32'd1);
    checkOutput("t1 mem_en",   32'(mem_en[0]),   32'd1);
    checkOutput("t1 mem_rw",   32'(mem_rw[0]),   32'd0);
    checkOutput("t1 mem_addr", mem_addr[0],      32'h100);
    next_cycle(); @(negedge clock);
    checkOutput("t1 inst_rvalid", 32'(inst_rvalid[0]), 32'd1);
    checkOutput("t1 inst_rdata",  inst_rdata[0],       32'hDEADBEEF);
    next_cycle(); @(negedge clock);
    checkOutput("t1 rvalid drops", 32'(inst_rvalid[0]), 32'd0);
    checkOutput("t1 rdata held",   inst_rdata[0],       32'hDEADBEEF);

    // Data write, then a read-back that proves the arbiter is idle at t+2.
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b1, 1'b1, 32'h200, 32'h12345678);
    @(negedge clock);
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t2 data_gnt",  32'(data_gnt[0]), 32'd1);
    checkOutput("t2 mem_rw",    32'(mem_rw[0]),   32'd1);
    checkOutput("t2 mem_addr",  mem_addr[0],      32'h200);
    checkOutput("t2 mem_wdata", mem_wdata[0],     32'h12345678);
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b1, 1'b0, 32'h200, '0);
    @(negedge clock);
    checkOutput("t2 no rvalid", 32'(data_rvalid[0]), 32'd0);
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t2 readback gnt", 32'(data_gnt[0]), 32'd1);
    next_cycle(); @(negedge clock);
    checkOutput("t2 readback rvalid", 32'(data_rvalid[0]), 32'd1);
    checkOutput("t2 readback rdata",  data_rdata[0],       32'h12345678);

    // Reset pulse clears the hold registers and the last winner.
    next_cycle(); reset = 1'b1;
    @(negedge clock);
    checkOutput("rst inst_rdata", inst_rdata[0], 32'h0);
    checkOutput("rst data_rdata", data_rdata[0], 32'h0);
    checkOutput("rst mem_en",     32'(mem_en[0]), 32'd0);
    next_cycle(); reset = 1'b0;

    // Both ports request together. Data wins, and inst follows once data drops.
    next_cycle(); applyStimulus(0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h400, '0);
    @(negedge clock);
    next_cycle(); applyStimulus(0, 1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t3 data_gnt first", 32'(data_gnt[0]), 32'd1);
    checkOutput("t3 inst waits",     32'(inst_gnt[0]), 32'd0);
    next_cycle(); @(negedge clock);
    checkOutput("t3 data_rvalid", 32'(data_rvalid[0]), 32'd1);
    checkOutput("t3 data_rdata",  data_rdata[0],       32'hC0DE0400);
    next_cycle(); @(negedge clock);
    checkOutput("t3 inst_gnt not yet", 32'(inst_gnt[0]), 32'd0);
    next_cycle(); applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t3 inst_gnt",  32'(inst_gnt[0]), 32'd1);
    checkOutput("t3 inst addr", mem_addr[0],      32'h300);
    next_cycle(); @(negedge clock);
    checkOutput("t3 inst_rvalid", 32'(inst_rvalid[0]), 32'd1);
    checkOutput("t3 inst_rdata",  inst_rdata[0],       32'hC0DE0300);
    next_cycle();

    // Both requests held for four grants. The last winner is inst here.
`ifdef MEM_ARB_RR_EN
    rr_expect_data = 4'b0101;
`else
    rr_expect_data = 4'b1111;
`endif
    next_cycle(); applyStimulus(0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, '0);
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checkOutput($sformatf("t4 grant %0d data", k), 32'(data_gnt[0]), 32'(rr_expect_data[k]));
      checkOutput($sformatf("t4 grant %0d inst", k), 32'(inst_gnt[0]), 32'(!rr_expect_data[k]));
      if (k < 3) repeat (2) next_cycle();
    end
    repeat (3) next_cycle();

    // LATENCY=3 data read, with an inst request raised during RESP.
    next_cycle(); applyStimulus(1, 1'b0, '0, 1'b1, 1'b0, 32'h700, '0);
    @(negedge clock);
    next_cycle(); applyStimulus(1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t5 data_gnt", 32'(data_gnt[1]), 32'd1);
    next_cycle(); @(negedge clock);
    checkOutput("t5 wait 1 rvalid", 32'(data_rvalid[1]), 32'd0);
    next_cycle(); @(negedge clock);
    checkOutput("t5 wait 2 rvalid", 32'(data_rvalid[1]), 32'd0);
    next_cycle(); applyStimulus(1, 1'b1, 32'h800, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t5 data_rvalid", 32'(data_rvalid[1]), 32'd1);
    checkOutput("t5 data_rdata",  data_rdata[1],       32'hC0DE0700);
    next_cycle(); @(negedge clock);
    checkOutput("t5 inst sampled in idle", 32'(inst_gnt[1]), 32'd0);
    checkOutput("t5 data_rdata held",      data_rdata[1],    32'hC0DE0700);
    next_cycle(); applyStimulus(1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t5 inst_gnt",  32'(inst_gnt[1]), 32'd1);
    checkOutput("t5 inst addr", mem_addr[1],      32'h800);
    repeat (3) next_cycle();
    @(negedge clock);
    checkOutput("t5 inst_rvalid", 32'(inst_rvalid[1]), 32'd1);
    checkOutput("t5 inst_rdata",  inst_rdata[1],       32'hC0DE0800);
    repeat (2) next_cycle();

    // Reset during WAIT drops the read. Nothing may follow without a request.
    next_cycle(); applyStimulus(1, 1'b0, '0, 1'b1, 1'b0, 32'h900, '0);
    @(negedge clock);
    next_cycle(); applyStimulus(1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t6 mem_en", 32'(mem_en[1]), 32'd1);
    next_cycle(); reset = 1'b1;
    @(negedge clock);
    checkOutput("t6 rst data_rdata", data_rdata[1],    32'h0);
    checkOutput("t6 rst inst_rdata", inst_rdata[1],    32'h0);
    checkOutput("t6 rst mem_addr",   mem_addr[1],      32'h0);
    checkOutput("t6 rst inst_rdata0", inst_rdata[0],   32'h0);
    checkOutput("t6 rst data_gnt",   32'(data_gnt[1]), 32'd0);
    next_cycle(); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checkOutput($sformatf("t6 quiet %0d rvalid", k), 32'(data_rvalid[1]), 32'd0);
      checkOutput($sformatf("t6 quiet %0d mem_en", k), 32'(mem_en[1]),      32'd0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the cpu instruction-fetch port and the cpu load/store port.
- Sits between cpu and memory and replaces their direct wiring.
- Accepts one transaction at a time, issues it to memory, and waits a fixed read latency. Read data is returned with a valid pulse to the requester that owns the transaction.
- Default arbitration is fixed priority, with data over instruction.

Parameters:
- LATENCY, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction read request; requester holds it until inst_gnt.
- inst_addr  in  AW  instruction address; must be stable while inst_req=1 and inst_gnt=0.
- inst_gnt  out  1  one-cycle pulse when the instruction request is issued to memory.
- inst_rvalid  out  1  one-cycle pulse when inst_rdata is valid.
- inst_rdata  out  DW  instruction read data.
- data_req  in  1  data request; held until data_gnt.
- data_rw  in  1  1 = write, 0 = read.
- data_addr  in  AW  data address.
- data_wdata  in  DW  write data.
- data_gnt  out  1  one-cycle pulse when the data request is issued.
- data_rvalid  out  1  one-cycle pulse when data_rdata is valid (reads only).
- data_rdata  out  DW  data read data.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_rw  out  1  1 = write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LATENCY cycles after the mem_en cycle.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. State is encoded in registers; outputs are decoded from state and registers.
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs are 0, including both rdata hold registers.
  - The owner register, the last-winner register (=inst), and the wait counter are cleared.
- IDLE:
  - If either request is high, select a winner.
  - Latch owner, addr, rw (forced 0 for inst) and wdata into the transaction register, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1, with mem_rw/addr/wdata driven from the transaction register.
  - The owner's gnt is 1.
  - Write: go to IDLE. Read: if LATENCY=1 go to RESP, else go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP (1 cycle):
  - The owner's rvalid is 1 and its rdata = mem_rdata (combinational pass-through).
  - The same value is captured into the owner's rdata hold register.
  - Go to IDLE.
- rdata outside RESP: each rdata output shows its hold register, i.e. the last response.
- Timing (request sampled high in IDLE at cycle t):
  - gnt and mem_en at t+1.
  - Read: rvalid at t+1+LATENCY, back in IDLE at t+2+LATENCY.
  - Write: back in IDLE at t+2.
- Requests are not sampled outside IDLE.
  - A request raised mid-transaction waits.
  - A requester keeping req high after gnt issues a new transaction at the next IDLE.
- Default arbitration: data_req wins whenever it is high in IDLE. Inst is starvable by design; the data port is the older pipeline stage.
- At most one gnt, one rvalid and one mem_en are high in any cycle.
- A request dropped before gnt is a protocol violation; the block does not recover it.
- Reset mid-operation drops the transaction. No gnt or rvalid follows reset deassertion unless there is a fresh request.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requests are high in IDLE, the requester that was not the last winner wins.
  - The last-winner register updates on every grant; its reset value is inst, so data wins the first tie.
  - A single requester always wins.
- Undefined: fixed data priority, and the last-winner register is not built.

Test Plan:
- LATENCY=1, inst_req=1, inst_addr=0x100 at t:
  - inst_gnt, mem_en=1, mem_rw=0, mem_addr=0x100 at t+1.
  - mem_rdata=0xDEADBEEF at t+2 -> inst_rvalid=1, inst_rdata=0xDEADBEEF at t+2.
  - inst_rdata holds 0xDEADBEEF afterwards.
- data_req=1, data_rw=1, addr=0x200, wdata=0x12345678 at t:
  - data_gnt, mem_en, mem_rw=1, mem_wdata=0x12345678 at t+1.
  - No rvalid; IDLE at t+2.
- Fixed priority, LATENCY=1, both reads requested at t and held:
  - data_gnt at t+1, data_rvalid at t+2.
  - inst_gnt at t+4, inst_rvalid at t+5.
- MEM_ARB_RR_EN, both requests held high for 4 reads -> grant order data, inst, data, inst.
- LATENCY=3, data read at t -> data_gnt at t+1, data_rvalid at t+4, IDLE at t+5.
- reset pulsed at t+2 during WAIT (LATENCY=3):
  - All outputs are 0 within the reset cycle.
  - After release with no requests -> no rvalid and no mem_en for 10 cycles.
